// File: rtl/rnd_hex_arbiter_pkg.sv
// rtl/rnd_hex_arbiter_pkg.sv - shared types and constants for the random hex-digit arbiter
//
// Purpose: FSM state encoding, LFSR tap mask, lockup replacement value and
//          the LFSR next-state helper shared by rnd_lfsr and rnd_hex_arbiter.
// Ports:   none (package).
package rnd_hex_arbiter_pkg;

  typedef enum logic {
    ST_WARMUP = 1'b0,
    ST_SERVE  = 1'b1
  } state_e;

  // Feedback taps r[15], r[14], r[13], r[3].
  localparam logic [15:0] LFSR_TAPS   = 16'hE008;
  // All-zero is a fixed point of an XOR LFSR; this value replaces it.
  localparam logic [15:0] LFSR_LOCKUP = 16'h0001;

  function automatic logic [15:0] lfsr_next(input logic [15:0] r);
    if (r == 16'h0000) begin
      return LFSR_LOCKUP;
    end
    return {r[14:0], ^(r & LFSR_TAPS)};
  endfunction

  function automatic logic [15:0] seed_fix(input logic [15:0] s);
    return (s == 16'h0000) ? LFSR_LOCKUP : s;
  endfunction

endpackage

// File: rtl/rnd_lfsr.sv
// rtl/rnd_lfsr.sv - 16-bit Fibonacci LFSR with step and seed load
//
// Purpose: random source for the arbiter. load has priority over step.
// Ports:   clk       - clock
//          rst       - synchronous active-high reset, loads RST_SEED
//          step      - advance one LFSR step this cycle
//          load      - load seed (zero replaced by the lockup value)
//          seed[15:0]- value for load
//          out[15:0] - current LFSR value
module rnd_lfsr
  import rnd_hex_arbiter_pkg::*;
#(
  parameter logic [15:0] RST_SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        step,
  input  logic        load,
  input  logic [15:0] seed,
  output logic [15:0] out
);

  logic [15:0] out_q;
  logic [15:0] out_d;

  always_comb begin
    out_d = out_q;
    if (load) begin
      out_d = seed_fix(seed);
    end else if (step) begin
      out_d = lfsr_next(out_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= RST_SEED;
    end else begin
      out_q <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: rtl/rnd_hex_arbiter.sv
// rtl/rnd_hex_arbiter.sv - round-robin arbiter handing out LFSR hex digits
//
// Purpose: after a warmup of WARMUP LFSR steps, grants one requester per
//          cycle in round-robin order and delivers LFSR[3:0] with the grant.
// Ports:   clk              - clock
//          rst              - synchronous active-high reset
//          i_seed_vld       - one-cycle strobe loading i_seed, restarts warmup
//          i_seed[15:0]     - new LFSR seed
//          i_req[N_REQ-1:0] - request levels
//          o_gnt[N_REQ-1:0] - registered one-hot grant pulse
//          o_digit[3:0]     - digit delivered with o_gnt, held otherwise
//          o_busy           - high during warmup
module rnd_hex_arbiter
  import rnd_hex_arbiter_pkg::*;
#(
  parameter int          N_REQ    = 4,
  parameter int          WARMUP   = 16,
  parameter logic [15:0] RST_SEED = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_seed_vld,
  input  logic [15:0]      i_seed,
  input  logic [N_REQ-1:0] i_req,
  output logic [N_REQ-1:0] o_gnt,
  output logic [3:0]       o_digit,
  output logic             o_busy
);

  localparam int         PW        = $clog2(N_REQ);
  localparam logic [7:0] WARM_LAST = 8'(WARMUP - 1);

  state_e           state_q, state_d;
  logic [7:0]       wcnt_q, wcnt_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [3:0]       digit_q, digit_d;

  logic        lfsr_step;
  logic        lfsr_load;
  logic [15:0] lfsr_val;
  logic        found;
  int          idx;

  rnd_lfsr #(
    .RST_SEED (RST_SEED)
  ) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .step (lfsr_step),
    .load (lfsr_load),
    .seed (i_seed),
    .out  (lfsr_val)
  );

  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    ptr_d     = ptr_q;
    gnt_d     = '0;
    digit_d   = digit_q;
    lfsr_step = 1'b0;
    lfsr_load = 1'b0;
    found     = 1'b0;
    idx       = 0;

    if (i_seed_vld) begin
      // Reseed wins over any grant this cycle; pointer is kept.
      lfsr_load = 1'b1;
      wcnt_d    = 8'd0;
      state_d   = ST_WARMUP;
    end else begin
      case (state_q)
        ST_WARMUP: begin
          lfsr_step = 1'b1;
          if (wcnt_q == WARM_LAST) begin
            state_d = ST_SERVE;
            wcnt_d  = 8'd0;
          end else begin
            wcnt_d = wcnt_q + 8'd1;
          end
        end
        ST_SERVE: begin
          // Search starts at ptr_q and wraps; first set request wins.
          for (int i = 0; i < N_REQ; i++) begin
            if (!found && i_req[(int'(ptr_q) + i) % N_REQ]) begin
              found = 1'b1;
              idx   = (int'(ptr_q) + i) % N_REQ;
            end
          end
          if (found) begin
            gnt_d[idx] = 1'b1;
            ptr_d      = PW'((idx + 1) % N_REQ);
            digit_d    = lfsr_val[3:0];
            lfsr_step  = 1'b1;
          end
        end
        default: state_d = ST_WARMUP;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_WARMUP;
      wcnt_q  <= 8'd0;
      ptr_q   <= '0;
      gnt_q   <= '0;
      digit_q <= 4'h0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      digit_q <= digit_d;
    end
  end

  assign o_gnt   = gnt_q;
  assign o_digit = digit_q;
  assign o_busy  = (state_q == ST_WARMUP);

endmodule
